// File: rtl/fsmc_pkg.sv
// Shared types and timing defaults for the multiplexed FSMC-style bus.
// The slave side and its bench import the same package.
package fsmc_pkg;

  typedef enum logic [2:0] {IDLE, ADDR, AHOLD, DATA, END, TURN} fsmc_state_e;

  localparam int ADDSET_DEF  = 2;
  localparam int ADDHLD_DEF  = 1;
  localparam int DATASET_DEF = 3;
  localparam int TURN_DEF    = 1;

  // Clocks from one accept edge to the next when requests are back to back.
  function automatic int txn_cycles(input int addset, input int addhld,
                                    input int dataset, input int turn);
    return 1 + addset + addhld + dataset + 1 + turn;
  endfunction

endpackage

// File: rtl/fsmc_phase_timer.sv
// Loadable down-counter that times each bus phase; done_o flags count==0.
module fsmc_phase_timer #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         done_o
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)            count <= '0;
    else if (load)           count <= value;
    else if (count != '0)    count <= count - 1'b1;
  end

  assign done_o = (count == '0);

endmodule

// File: rtl/fsmc_master.sv
// Initiator of the multiplexed FSMC bus: address phase under NADV, then a
// write (NWE) or read (NOE) data phase on the shared AD lines.
module fsmc_master
  import fsmc_pkg::*;
#(
  parameter int ADDR_WIDTH     = 18,
  parameter int DATA_WIDTH     = 16,
  parameter int ADDSET_CYCLES  = ADDSET_DEF,
  parameter int ADDHLD_CYCLES  = ADDHLD_DEF,
  parameter int DATASET_CYCLES = DATASET_DEF,
  parameter int TURN_CYCLES    = TURN_DEF
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  busy,
  inout  wire  [ADDR_WIDTH-1:0] AD,
  output logic                  NADV,
  output logic                  NWE,
  output logic                  NOE
);

  localparam int MAX_AB = (ADDSET_CYCLES > ADDHLD_CYCLES) ? ADDSET_CYCLES : ADDHLD_CYCLES;
  localparam int MAX_CD = (DATASET_CYCLES > TURN_CYCLES) ? DATASET_CYCLES : TURN_CYCLES;
  localparam int MAXP   = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int CW     = $clog2(MAXP) + 1;

  if (ADDR_WIDTH <= DATA_WIDTH) begin : g_bad_width
    $error("ADDR_WIDTH must exceed DATA_WIDTH");
  end
  if (ADDSET_CYCLES < 1) begin : g_bad_addset
    $error("ADDSET_CYCLES must be >= 1");
  end
  if (ADDHLD_CYCLES < 1) begin : g_bad_addhld
    $error("ADDHLD_CYCLES must be >= 1");
  end
  if (DATASET_CYCLES < 2) begin : g_bad_dataset
    $error("DATASET_CYCLES must be >= 2");
  end
  if (TURN_CYCLES < 1) begin : g_bad_turn
    $error("TURN_CYCLES must be >= 1");
  end

  fsmc_state_e           state, state_n;
  logic                  cap_write;
  logic [ADDR_WIDTH-1:0] cap_addr;
  logic [DATA_WIDTH-1:0] cap_wdata;
  logic                  accept;
  logic                  tmr_load, tmr_done;
  logic [CW-1:0]         tmr_val;

  logic                  wr_n;
  logic [ADDR_WIDTH-1:0] addr_n;
  logic [DATA_WIDTH-1:0] wdata_n;
  logic                  nadv_d, nwe_d, noe_d, oe_d;
  logic [ADDR_WIDTH-1:0] ad_d;
  logic                  ad_oe;
  logic [ADDR_WIDTH-1:0] ad_q;
  logic                  ad_hi_unused;

  assign accept    = req_valid && (state == IDLE);
  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  fsmc_phase_timer #(.W(CW)) u_timer (
    .clk    (clk),
    .reset_n(reset_n),
    .load   (tmr_load),
    .value  (tmr_val),
    .done_o (tmr_done)
  );

  always_comb begin
    state_n  = state;
    tmr_load = 1'b0;
    tmr_val  = '0;
    case (state)
      IDLE:  if (req_valid) begin
               state_n = ADDR;  tmr_load = 1'b1; tmr_val = CW'(ADDSET_CYCLES - 1);
             end
      ADDR:  if (tmr_done) begin
               state_n = AHOLD; tmr_load = 1'b1; tmr_val = CW'(ADDHLD_CYCLES - 1);
             end
      AHOLD: if (tmr_done) begin
               state_n = DATA;  tmr_load = 1'b1; tmr_val = CW'(DATASET_CYCLES - 1);
             end
      DATA:  if (tmr_done) state_n = END;
      END:   begin
               state_n = TURN;  tmr_load = 1'b1; tmr_val = CW'(TURN_CYCLES - 1);
             end
      TURN:  if (tmr_done) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Pin values are decoded from the next state so every pin leaves a flop
  // in the same cycle the state does; the accept cycle forwards the request.
  always_comb begin
    wr_n    = accept ? req_write : cap_write;
    addr_n  = accept ? req_addr  : cap_addr;
    wdata_n = accept ? req_wdata : cap_wdata;
    nadv_d  = (state_n != ADDR);
    nwe_d   = !((state_n == DATA) &&  wr_n);
    noe_d   = !((state_n == DATA) && !wr_n);
    oe_d    = (state_n == ADDR) || (state_n == AHOLD) ||
              (((state_n == DATA) || (state_n == END)) && wr_n);
    ad_d    = ((state_n == ADDR) || (state_n == AHOLD)) ? addr_n
              : {{(ADDR_WIDTH-DATA_WIDTH){1'b0}}, wdata_n};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cap_write <= 1'b0;
      cap_addr  <= '0;
      cap_wdata <= '0;
      NADV      <= 1'b1;
      NWE       <= 1'b1;
      NOE       <= 1'b1;
      ad_oe     <= 1'b0;
      ad_q      <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      state     <= state_n;
      if (accept) begin
        cap_write <= req_write;
        cap_addr  <= req_addr;
        cap_wdata <= req_wdata;
      end
      NADV      <= nadv_d;
      NWE       <= nwe_d;
      NOE       <= noe_d;
      ad_oe     <= oe_d;
      ad_q      <= ad_d;
      rsp_valid <= (state_n == END);
      // Last read data cycle: NOE is still low here and rises on this edge.
      if ((state == DATA) && tmr_done && !cap_write)
        rsp_rdata <= AD[DATA_WIDTH-1:0];
    end
  end

  assign AD = ad_oe ? ad_q : 'z;

  // The module-select bits are never read back.
  assign ad_hi_unused = ^AD[ADDR_WIDTH-1:DATA_WIDTH];

endmodule

// File: tb/tb_fsmc_master.sv
// Directed bench for fsmc_master with a small slave memory model on AD.
module tb_fsmc_master;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        req_valid = 1'b0, req_write = 1'b0;
  logic [17:0] req_addr = '0;
  logic [15:0] req_wdata = '0;
  logic        req_ready, rsp_valid, busy, NADV, NWE, NOE;
  logic [15:0] rsp_rdata;
  wire  [17:0] AD;

  logic        rv_f = 1'b0, rr_f, rsv_f, busy_f, nadv_f, nwe_f, noe_f;
  logic [15:0] rd_f;
  wire  [17:0] ad_f;
  logic        rv_s = 1'b0, rr_s, rsv_s, busy_s, nadv_s, nwe_s, noe_s;
  logic [15:0] rd_s;
  wire  [17:0] ad_s;

  int n_cmp = 0, n_err = 0, rsp_cnt = 0;

  always #5 clk = ~clk;

  fsmc_master dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy),
    .AD(AD), .NADV(NADV), .NWE(NWE), .NOE(NOE));

  fsmc_master #(.ADDSET_CYCLES(1), .ADDHLD_CYCLES(1), .DATASET_CYCLES(2), .TURN_CYCLES(1)) dut_f (
    .clk(clk), .reset_n(reset_n), .req_valid(rv_f), .req_ready(rr_f),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsv_f), .rsp_rdata(rd_f), .busy(busy_f),
    .AD(ad_f), .NADV(nadv_f), .NWE(nwe_f), .NOE(noe_f));

  fsmc_master #(.ADDSET_CYCLES(4), .DATASET_CYCLES(8)) dut_s (
    .clk(clk), .reset_n(reset_n), .req_valid(rv_s), .req_ready(rr_s),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsv_s), .rsp_rdata(rd_s), .busy(busy_s),
    .AD(ad_s), .NADV(nadv_s), .NWE(nwe_s), .NOE(noe_s));

  // Slave model: latch address as NADV rises, store on NWE rise, drive while NOE low.
  logic [15:0] smem [16];
  logic [17:0] s_addr = '0;
  logic [15:0] s_rd = '0;
  always @(posedge NADV) s_addr = AD;
  always @(posedge NWE)  smem[s_addr[3:0]] = AD[15:0];
  always @(negedge NOE)  s_rd = smem[s_addr[3:0]];
  assign AD = !NOE ? {2'b00, s_rd} : 'z;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rsp_valid) rsp_cnt++;
    if (reset_n)
      chk("strobe_excl", {31'd0, (!NWE && !NOE) || (!NOE && dut.ad_oe) ||
                                 (!NADV && (!NWE || !NOE))}, 32'd0);
  end

  task automatic do_txn(input logic w, input logic [17:0] a, input logic [15:0] d);
    int n = 0;
    @(negedge clk);
    while (!req_ready && n < 40) begin @(negedge clk); n++; end
    chk("ready_wait", {31'd0, n < 40}, 32'd1);
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic wait_rsp();
    int n = 0;
    while (!rsp_valid && n < 20) begin @(negedge clk); n++; end
    chk("rsp_wait", {31'd0, n < 20}, 32'd1);
  endtask

  // Default timing: ADDR 1-2, AHOLD 3, DATA 4-6, END 7, TURN 8, ready 9.
  task automatic check_txn(input logic wr, input logic [17:0] a, input logic [15:0] d,
                           input logic [15:0] rd);
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      chk("nadv",  NADV, !(k <= 2));
      chk("nwe",   NWE,  !(wr && k >= 4 && k <= 6));
      chk("noe",   NOE,  !(!wr && k >= 4 && k <= 6));
      chk("ad_oe", dut.ad_oe, (k <= 3) || (wr && k >= 4 && k <= 7));
      chk("rsp_valid", rsp_valid, k == 7);
      chk("req_ready", req_ready, k == 9);
      if (k <= 3)            chk("ad_addr", AD, a);
      else if (wr && k <= 7) chk("ad_wdata", AD, {2'b00, d});
      else if (k <= 6)       chk("ad_slave", AD[15:0], rd);
      if (k == 7)            chk("rsp_rdata", rsp_rdata, rd);
    end
  endtask

  initial begin
    int acc[$], acc_f[$], acc_s[$];
    int nadv_lo, nwe_lo, snap;
    logic [15:0] sb [16];
    logic [3:0]  a4;
    logic [15:0] d;
    logic        w;

    foreach (smem[i]) smem[i] = '0;
    #2 reset_n = 1'b0;
    #3;
    chk("rst_nadv", NADV, 1); chk("rst_nwe", NWE, 1); chk("rst_noe", NOE, 1);
    chk("rst_oe", dut.ad_oe, 0); chk("rst_ready", req_ready, 1);
    chk("rst_busy", busy, 0); chk("rst_rspv", rsp_valid, 0); chk("rst_rdata", rsp_rdata, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    do_txn(1'b1, 18'h2_1234, 16'hBEEF);
    check_txn(1'b1, 18'h2_1234, 16'hBEEF, 16'h0000);

    smem[0] = 16'hA5A5;
    do_txn(1'b0, 18'h1_0040, 16'h0000);
    check_txn(1'b0, 18'h1_0040, 16'h0000, 16'hA5A5);

    do_txn(1'b1, 18'h2_1235, 16'h1111);
    check_txn(1'b1, 18'h2_1235, 16'h1111, 16'hA5A5);

    // req_valid held high with changing request fields: only IDLE accepts.
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      if (i == 1)  chk("b2b_ad0", AD, 18'h1_0000);
      if (i == 10) chk("b2b_ad1", AD, 18'h1_0009);
      if (req_ready) acc.push_back(i);
      req_valid = 1'b1; req_write = i[0]; req_addr = 18'h1_0000 + 18'(i); req_wdata = 16'(i);
    end
    @(negedge clk) req_valid = 1'b0;
    chk("b2b_accepts", acc.size(), 2);
    chk("b2b_gap", (acc.size() >= 2) ? acc[1] - acc[0] : 0, 9);
    repeat (12) @(negedge clk);

    // Reset during cycle 5 of a write.
    do_txn(1'b1, 18'h2_0055, 16'h7777);
    repeat (5) @(negedge clk);
    chk("mid_nwe_low", NWE, 0);
    snap = rsp_cnt;
    reset_n = 1'b0;
    #1;
    chk("mid_nwe", NWE, 1); chk("mid_oe", dut.ad_oe, 0);
    chk("mid_nadv", NADV, 1); chk("mid_ready", req_ready, 1);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("mid_no_rsp", rsp_cnt, snap);
    chk("mid_ready2", req_ready, 1);
    do_txn(1'b1, 18'h2_0056, 16'h4242);
    check_txn(1'b1, 18'h2_0056, 16'h4242, 16'h0000);

    // Timing extremes: fast 1+1+1+2+1+1 = 7, slow 1+4+1+8+1+1 = 16.
    nadv_lo = 0; nwe_lo = 0;
    req_write = 1'b1; req_addr = 18'h3_0001; req_wdata = 16'h5A5A;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rr_f) acc_f.push_back(i);
      if (rr_s) acc_s.push_back(i);
      if (i >= 1 && i <= 15) begin
        nadv_lo += int'(!nadv_s);
        nwe_lo  += int'(!nwe_s);
      end
      rv_f = 1'b1; rv_s = 1'b1;
    end
    @(negedge clk) begin rv_f = 1'b0; rv_s = 1'b0; end
    chk("fast_gap", (acc_f.size() >= 2) ? acc_f[1] - acc_f[0] : 0, 7);
    chk("slow_gap", (acc_s.size() >= 2) ? acc_s[1] - acc_s[0] : 0, 16);
    chk("slow_nadv_len", nadv_lo, 4);
    chk("slow_nwe_len", nwe_lo, 8);
    repeat (20) @(negedge clk);

    // Loopback against the slave model, module-select field 2'b01.
    do_txn(1'b1, 18'h1_0000, 16'h1357);
    wait_rsp();
    do_txn(1'b0, 18'h1_0000, 16'h0000);
    wait_rsp();
    chk("lb_1357", rsp_rdata, 16'h1357);
    for (int i = 0; i < 16; i++) begin
      a4 = 4'(i); d = 16'($urandom);
      do_txn(1'b1, {2'b01, 12'h000, a4}, d);
      sb[a4] = d;
      wait_rsp();
    end
    for (int n = 0; n < 300; n++) begin
      w = 1'($urandom_range(0, 1)); a4 = 4'($urandom_range(0, 15)); d = 16'($urandom);
      do_txn(w, {2'b01, 12'h000, a4}, d);
      wait_rsp();
      if (w) sb[a4] = d;
      else   chk("lb_read", rsp_rdata, sb[a4]);
    end

    repeat (4) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
    $fatal(1, "watchdog");
  end

endmodule
